// File: rtl/double_to_sig16b.sv
// Three-register pipeline converting an IEEE-754 binary64 sample to a saturated,
// round-half-to-even signed 16-bit value, published on sample-frame phase 0.
module double_to_sig16b (
    input  logic        clk_operation,
    input  logic        rst,
    input  logic        enable,
    input  logic [63:0] double,
    input  logic [12:0] sampling_cycle_counter,
    output logic [15:0] sig16b
);

    logic               s0_valid_q;
    logic [63:0]        s0_data_q;

    logic               s1_valid_q;
    logic               s1_sign_q;
    logic               s1_nan_q;
    logic               s1_inf_q;
    logic               s1_zero_q;
    logic signed [11:0] s1_exp_q;
    logic [52:0]        s1_mant_q;

    logic               s1_sign_d;
    logic               s1_nan_d;
    logic               s1_inf_d;
    logic               s1_zero_d;
    logic signed [11:0] s1_exp_d;
    logic [52:0]        s1_mant_d;

    logic [15:0]        pending_q;
    logic [15:0]        pending_d;
    logic [15:0]        sig16b_q;

    logic [10:0]        raw_exp;
    logic [51:0]        raw_frac;

    logic [5:0]         shamt;
    logic [15:0]        int_part;
    logic               guard;
    logic               sticky;
    logic [52:0]        rem_mask;
    logic [16:0]        mag;

    assign sig16b = sig16b_q;

    always_comb begin
        raw_exp   = s0_data_q[62:52];
        raw_frac  = s0_data_q[51:0];
        s1_sign_d = s0_data_q[63];
        s1_nan_d  = (raw_exp == 11'h7FF) && (raw_frac != '0);
        s1_inf_d  = (raw_exp == 11'h7FF) && (raw_frac == '0);
        s1_zero_d = (raw_exp == '0);
        s1_exp_d  = $signed({1'b0, raw_exp}) - 12'sd1023;
        s1_mant_d = {(raw_exp != '0), raw_frac};
    end

    // Only -1 <= e <= 15 reaches the shifter, so the shift stays within 37..53
    // and the integer part always fits in 16 bits before the rounding increment.
    always_comb begin
        shamt     = '0;
        int_part  = '0;
        guard     = 1'b0;
        sticky    = 1'b0;
        rem_mask  = '0;
        mag       = '0;
        pending_d = '0;
        if (s1_nan_q || s1_zero_q) begin
            pending_d = '0;
        end else if (s1_inf_q || (s1_exp_q >= 12'sd16)) begin
            pending_d = s1_sign_q ? 16'h8000 : 16'h7FFF;
        end else if (s1_exp_q < -12'sd1) begin
            pending_d = '0;
        end else begin
            shamt    = 6'(12'sd52 - s1_exp_q);
            int_part = 16'(s1_mant_q >> shamt);
            guard    = s1_mant_q[shamt - 6'd1];
            rem_mask = ~({53{1'b1}} << (shamt - 6'd1));
            sticky   = |(s1_mant_q & rem_mask);
            mag      = {1'b0, int_part} + {16'd0, guard & (sticky | int_part[0])};
            if (s1_sign_q) begin
                pending_d = (mag > 17'd32768) ? 16'h8000 : 16'(-mag);
            end else begin
                pending_d = (mag > 17'd32767) ? 16'h7FFF : mag[15:0];
            end
        end
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            pending_q  <= '0;
            sig16b_q   <= '0;
        end else begin
            s0_valid_q <= enable;
            if (enable) begin
                s0_data_q <= double;
            end
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_sign_q <= s1_sign_d;
                s1_nan_q  <= s1_nan_d;
                s1_inf_q  <= s1_inf_d;
                s1_zero_q <= s1_zero_d;
                s1_exp_q  <= s1_exp_d;
                s1_mant_q <= s1_mant_d;
            end
            if (s1_valid_q) begin
                pending_q <= pending_d;
            end
            if (sampling_cycle_counter == '0) begin
                sig16b_q <= pending_q;
            end
        end
    end

endmodule

// File: tb/tb_double_to_sig16b.sv
// Directed-vector bench for double_to_sig16b: rounding, saturation, special
// values, output-phase gating and reset discard.
module tb_double_to_sig16b;

    logic        clk_operation;
    logic        rst;
    logic        enable;
    logic [63:0] double;
    logic [12:0] sampling_cycle_counter;
    logic [15:0] sig16b;

    int unsigned tests_run;
    int unsigned tests_failed;

    double_to_sig16b dut (
        .clk_operation          (clk_operation),
        .rst                    (rst),
        .enable                 (enable),
        .double                 (double),
        .sampling_cycle_counter (sampling_cycle_counter),
        .sig16b                 (sig16b)
    );

    initial clk_operation = 1'b0;
    always #5 clk_operation = ~clk_operation;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Called at a negedge: one-cycle enable pulse, publish on the third edge after capture.
    task automatic convert(input string tag, input logic [63:0] d, input logic [15:0] exp);
        double                 = d;
        enable                 = 1'b1;
        sampling_cycle_counter = 13'd5;
        @(negedge clk_operation);
        enable = 1'b0;
        @(negedge clk_operation);
        @(negedge clk_operation);
        sampling_cycle_counter = 13'd0;
        @(negedge clk_operation);
        check(tag, sig16b, exp);
        sampling_cycle_counter = 13'd5;
        @(negedge clk_operation);
    endtask

    initial begin
        tests_run              = 0;
        tests_failed           = 0;
        rst                    = 1'b1;
        enable                 = 1'b1;
        double                 = 64'h4093480000000000;
        sampling_cycle_counter = 13'd0;
        repeat (3) @(negedge clk_operation);
        check("reset_state", sig16b, 16'h0000);

        // First conversion accepted on the first edge after reset release.
        rst    = 1'b0;
        double = 64'h4059000000000000;
        sampling_cycle_counter = 13'd5;
        @(negedge clk_operation);
        enable = 1'b0;
        @(negedge clk_operation);
        @(negedge clk_operation);
        sampling_cycle_counter = 13'd0;
        @(negedge clk_operation);
        check("first_after_reset", sig16b, 16'h0064);
        sampling_cycle_counter = 13'd5;
        @(negedge clk_operation);

        convert("p1234",       64'h4093480000000000, 16'h04D2);
        convert("m2p5",        64'hC004000000000000, 16'hFFFE);
        convert("p1p5",        64'h3FF8000000000000, 16'h0002);
        convert("p2p5",        64'h4004000000000000, 16'h0002);
        convert("p0p5",        64'h3FE0000000000000, 16'h0000);
        convert("p0p75",       64'h3FE8000000000000, 16'h0001);
        convert("m1",          64'hBFF0000000000000, 16'hFFFF);
        convert("p40000",      64'h40E3880000000000, 16'h7FFF);
        convert("m40000",      64'hC0E3880000000000, 16'h8000);
        convert("nan",         64'h7FF8000000000000, 16'h0000);
        convert("pinf",        64'h7FF0000000000000, 16'h7FFF);
        convert("minf",        64'hFFF0000000000000, 16'h8000);
        convert("mzero",       64'h8000000000000000, 16'h0000);
        convert("p32767",      64'h40DFFFC000000000, 16'h7FFF);
        convert("p32767p5",    64'h40DFFFE000000000, 16'h7FFF);
        convert("p32766",      64'h40DFFF8000000000, 16'h7FFE);
        convert("m32768",      64'hC0E0000000000000, 16'h8000);
        convert("m32769",      64'hC0E0002000000000, 16'h8000);
        convert("p1234_again", 64'h4093480000000000, 16'h04D2);

        // Output holds while counter != 0, then loads the waiting result.
        double = 64'h4059000000000000;
        enable = 1'b1;
        @(negedge clk_operation);
        enable = 1'b0;
        repeat (6) @(negedge clk_operation);
        check("hold_nonzero_phase", sig16b, 16'h04D2);
        sampling_cycle_counter = 13'd0;
        @(negedge clk_operation);
        check("load_at_phase0", sig16b, 16'h0064);

        // Back-to-back captures with counter held at 0; output lags pending by one edge.
        double = 64'h3FF0000000000000;
        enable = 1'b1;
        @(negedge clk_operation);
        double = 64'h4000000000000000;
        @(negedge clk_operation);
        double = 64'h4008000000000000;
        @(negedge clk_operation);
        enable = 1'b0;
        check("pipe_same_edge_old", sig16b, 16'h0064);
        @(negedge clk_operation);
        check("pipe_first", sig16b, 16'h0001);
        @(negedge clk_operation);
        check("pipe_second", sig16b, 16'h0002);
        @(negedge clk_operation);
        check("pipe_third", sig16b, 16'h0003);

        // Reset one edge after capture discards the in-flight conversion.
        double = 64'h4093480000000000;
        enable = 1'b1;
        @(negedge clk_operation);
        enable = 1'b0;
        rst    = 1'b1;
        @(negedge clk_operation);
        rst = 1'b0;
        check("reset_clears_out", sig16b, 16'h0000);
        repeat (4) @(negedge clk_operation);
        check("reset_discard", sig16b, 16'h0000);
        sampling_cycle_counter = 13'd5;
        convert("post_reset_conv", 64'hBFF8000000000000, 16'hFFFE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
